// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destinations after EX and selects forward sources or stalls.
// Optional stall performance counter enabled by defining FWD_PERF_EN.
module fwd_scoreboard #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int LW    = 2,
  localparam int SW   = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_wen,
  input  logic [AW-1:0]       ex_waddr,
  input  logic [LW-1:0]       ex_lat,
  input  logic [NSRC*AW-1:0]  ex_src,
  input  logic                hold,
  input  logic                flush,
  output logic [NSRC*SW-1:0]  fwd_sel,
`ifdef FWD_PERF_EN
  output logic                stall,
  output logic [31:0]         stall_cnt
`else
  output logic                stall
`endif
);

  logic [DEPTH-1:0] slot_vld;
  logic [AW-1:0]    slot_addr [DEPTH];
  logic [LW-1:0]    slot_cnt  [DEPTH];

  logic [SW-1:0]    sel_arr [NSRC];
  logic [NSRC-1:0]  blk_arr;
  logic             enter;

  function automatic logic [LW-1:0] dec_sat(input logic [LW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Operand lookup: scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      sel_arr[k] = '0;
      blk_arr[k] = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (slot_vld[i] && (slot_addr[i] != '0) &&
            (slot_addr[i] == ex_src[k*AW +: AW])) begin
          blk_arr[k] = (slot_cnt[i] != '0);
          sel_arr[k] = (slot_cnt[i] != '0) ? '0 : SW'(i + 1);
        end
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_sel
    assign fwd_sel[g*SW +: SW] = sel_arr[g];
  end

  assign stall = ex_valid & (|blk_arr);
  assign enter = ex_valid & ex_wen & ~stall & ~flush;

  // Slot valid bits: the only state that reset must clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld <= '0;
    end else if (!hold) begin
      slot_vld[0] <= enter;
      for (int i = 1; i < DEPTH; i++) slot_vld[i] <= slot_vld[i-1];
    end
  end

  // Slot payload: address and remaining latency shift with the valid bits.
  always_ff @(posedge clk) begin
    if (!hold) begin
      slot_addr[0] <= ex_waddr;
      slot_cnt[0]  <= ex_lat;
      for (int i = 1; i < DEPTH; i++) begin
        slot_addr[i] <= slot_addr[i-1];
        slot_cnt[i]  <= dec_sat(slot_cnt[i-1]);
      end
    end
  end

`ifdef FWD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)             stall_cnt <= '0;
    else if (stall && !hold) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table followed by random stimulus against an age-based model.
module tb_fwd_scoreboard;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int LW    = 2;
  localparam int SW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n, ex_valid, ex_wen, hold, flush, stall;
  logic [AW-1:0] ex_waddr;
  logic [LW-1:0] ex_lat;
  logic [NSRC*AW-1:0] ex_src;
  logic [NSRC*SW-1:0] fwd_sel;
`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fwd_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wen(ex_wen),
    .ex_waddr(ex_waddr), .ex_lat(ex_lat), .ex_src(ex_src),
    .hold(hold), .flush(flush), .fwd_sel(fwd_sel),
`ifdef FWD_PERF_EN
    .stall(stall), .stall_cnt(stall_cnt)
`else
    .stall(stall)
`endif
  );

  // Model: each issued writer remembers the advance index at which it entered slot 0.
  typedef struct {int addr; int lat; int enter;} ent_t;
  ent_t hist[$];
  int   adv;
  int   exp_perf;
  bit   model_ok;

  typedef struct {
    bit r, v, w; int wa, lat, s0, s1; bit h, f, chk; int e0, e1; bit es;
  } vec_t;
  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval(input int src, output int sel, output bit blk);
    int best_s = DEPTH;
    int best_lat = 0;
    foreach (hist[j]) begin
      int s = adv - 1 - hist[j].enter;
      if (s < DEPTH && hist[j].addr != 0 && hist[j].addr == src && s < best_s) begin
        best_s = s;
        best_lat = hist[j].lat;
      end
    end
    blk = (best_s < DEPTH) && (best_lat > best_s);
    sel = (best_s < DEPTH && !blk) ? best_s + 1 : 0;
  endfunction

  task automatic step(input vec_t t, input string tag);
    int m0, m1;
    bit b0, b1, ms;
    @(negedge clk);
    rst_n = t.r; ex_valid = t.v; ex_wen = t.w;
    ex_waddr = AW'(t.wa); ex_lat = LW'(t.lat);
    ex_src = {AW'(t.s1), AW'(t.s0)};
    hold = t.h; flush = t.f;
    #1;
    if (t.chk) begin
      check({tag, ".sel0"}, int'(fwd_sel[SW-1:0]), t.e0);
      check({tag, ".sel1"}, int'(fwd_sel[2*SW-1:SW]), t.e1);
      check({tag, ".stall"}, int'(stall), int'(t.es));
    end
    model_eval(t.s0, m0, b0);
    model_eval(t.s1, m1, b1);
    ms = t.v & (b0 | b1);
    if (model_ok) begin
      check({tag, ".model_sel0"}, int'(fwd_sel[SW-1:0]), m0);
      check({tag, ".model_sel1"}, int'(fwd_sel[2*SW-1:SW]), m1);
      check({tag, ".model_stall"}, int'(stall), int'(ms));
`ifdef FWD_PERF_EN
      check({tag, ".stall_cnt"}, int'(stall_cnt), exp_perf);
`endif
    end
    @(posedge clk);
    if (!t.r) begin
      hist.delete();
      adv = 0;
      exp_perf = 0;
      model_ok = 1'b1;
    end else if (!t.h) begin
      if (ms) exp_perf++;
      if (t.v && t.w && !ms && !t.f) hist.push_back('{t.wa, t.lat, adv});
      adv++;
      while (hist.size() > 0 && (adv - 1 - hist[0].enter) >= DEPTH) void'(hist.pop_front());
    end
  endtask

  function automatic void add(input bit r, v, w, input int wa, lat, s0, s1,
                              input bit h, f, chk, input int e0, e1, input bit es);
    vec_t t;
    t.r = r; t.v = v; t.w = w; t.wa = wa; t.lat = lat; t.s0 = s0; t.s1 = s1;
    t.h = h; t.f = f; t.chk = chk; t.e0 = e0; t.e1 = e1; t.es = es;
    tbl.push_back(t);
  endfunction

  initial begin
    vec_t t;
    adv = 0; exp_perf = 0; model_ok = 1'b0;
    rst_n = 1'b0; ex_valid = 1'b0; ex_wen = 1'b0; ex_waddr = '0; ex_lat = '0;
    ex_src = '0; hold = 1'b0; flush = 1'b0;

    //   r v w wa lat s0 s1 h f chk e0 e1 es
    add(0,0,0, 0, 0, 0, 0, 0,0, 0, 0, 0, 0);  // reset
    add(1,1,1, 5, 0, 0, 0, 0,0, 1, 0, 0, 0);  // ALU writes r5
    add(1,1,0, 0, 0, 5, 0, 0,0, 1, 1, 0, 0);  // back-to-back: slot 0
    add(1,1,0, 0, 0, 5, 0, 0,0, 1, 2, 0, 0);  // one later: slot 1
    add(1,1,1, 7, 1, 0, 0, 0,0, 1, 0, 0, 0);  // load r7
    add(1,1,0, 0, 0, 0, 7, 0,0, 1, 0, 0, 1);  // load-use stall
    add(1,1,0, 0, 0, 0, 7, 0,0, 1, 0, 2, 0);  // then forward from slot 1
    add(1,1,1, 3, 0, 0, 0, 0,0, 1, 0, 0, 0);  // r3 lat 0
    add(1,1,1, 3, 1, 0, 0, 0,0, 1, 0, 0, 0);  // r3 lat 1 (younger)
    add(1,1,0, 0, 0, 3, 0, 0,0, 1, 0, 0, 1);  // youngest blocks
    add(1,1,0, 0, 0, 3, 0, 0,0, 1, 2, 0, 0);
    add(1,1,1, 0, 0, 0, 0, 0,0, 1, 0, 0, 0);  // writes r0
    add(1,1,0, 0, 0, 0, 0, 0,0, 1, 0, 0, 0);  // r0 never forwards
    add(1,1,1, 7, 1, 0, 0, 0,0, 1, 0, 0, 0);  // load r7
    add(1,1,0, 0, 0, 0, 7, 1,0, 1, 0, 0, 1);  // hold x3 keeps stall
    add(1,1,0, 0, 0, 0, 7, 1,0, 1, 0, 0, 1);
    add(1,1,0, 0, 0, 0, 7, 1,0, 1, 0, 0, 1);
    add(1,1,0, 0, 0, 0, 7, 0,0, 1, 0, 0, 1);  // release: still one stall
    add(1,1,0, 0, 0, 0, 7, 0,0, 1, 0, 2, 0);
    add(1,1,1, 9, 0, 0, 0, 0,1, 1, 0, 0, 0);  // flushed writer r9
    add(1,1,0, 0, 0, 9, 0, 0,0, 1, 0, 0, 0);
    add(1,1,1, 1, 0, 0, 0, 0,0, 1, 0, 0, 0);  // fill three slots
    add(1,1,1, 2, 0, 0, 0, 0,0, 1, 0, 0, 0);
    add(1,1,1, 4, 0, 0, 0, 0,0, 1, 0, 0, 0);
    add(0,1,0, 0, 0, 4, 2, 0,0, 1, 1, 2, 0);  // reset with full slots
    add(1,1,0, 0, 0, 4, 1, 0,0, 1, 0, 0, 0);  // everything discarded
    add(1,1,1, 6, 3, 0, 0, 0,0, 1, 0, 0, 0);  // latency beyond depth
    add(1,1,0, 0, 0, 6, 0, 0,0, 1, 0, 0, 1);
    add(1,1,0, 0, 0, 6, 0, 0,0, 1, 0, 0, 1);
    add(1,1,0, 0, 0, 6, 0, 0,0, 1, 0, 0, 1);
    add(1,1,0, 0, 0, 6, 0, 0,0, 1, 0, 0, 0);  // retired: register file
    add(1,0,0, 0, 0, 0, 0, 0,0, 1, 0, 0, 0);

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    for (int c = 0; c < 3000; c++) begin
      t.r   = ($urandom_range(0, 63) != 0);
      t.v   = ($urandom_range(0, 7) != 0);
      t.w   = ($urandom_range(0, 3) != 0);
      t.wa  = $urandom_range(0, 3);
      t.lat = $urandom_range(0, 3);
      t.s0  = $urandom_range(0, 3);
      t.s1  = $urandom_range(0, 3);
      t.h   = ($urandom_range(0, 4) == 0);
      t.f   = ($urandom_range(0, 9) == 0);
      t.chk = 1'b0; t.e0 = 0; t.e1 = 0; t.es = 1'b0;
      step(t, $sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
